// File: rtl/fp_mantissa_adder_pkg.sv
// Shared FP datapath definitions: mantissa width (hidden bit included)
// and the mantissa / raw-sum types used around the mantissa adder.
package fp_mantissa_adder_pkg;

    localparam int MANT_W = 24;

    typedef logic [MANT_W-1:0] mantissa_t;
    typedef logic [MANT_W:0]   sum_t;

endpackage

// File: rtl/mantissa_addsub_core.sv
// Combinational sign-magnitude add/subtract of two aligned mantissas.
// Produces a non-negative magnitude one bit wider than the operands plus its sign.
module mantissa_addsub_core
    import fp_mantissa_adder_pkg::*;
#(
    parameter int W = MANT_W
) (
    input  logic         sign_a,
    input  logic         sign_b,
    input  logic [W-1:0] mantissa_a,
    input  logic [W-1:0] mantissa_b,
    output logic [W:0]   sum,
    output logic         sign
);

    logic a_gt_b;
    logic a_eq_b;

    assign a_gt_b = (mantissa_a > mantissa_b);
    assign a_eq_b = (mantissa_a == mantissa_b);

    // NOTE: every output gets a default first so no path through the
    // branches can leave it unassigned and infer a latch.
    always_comb begin
        sum  = '0;
        sign = 1'b0;
        if (sign_a == sign_b) begin
            sum  = {1'b0, mantissa_a} + {1'b0, mantissa_b};
            sign = sign_a;
        end else if (a_gt_b) begin
            sum  = {1'b0, mantissa_a - mantissa_b};
            sign = sign_a;
        end else if (!a_eq_b) begin
            sum  = {1'b0, mantissa_b - mantissa_a};
            sign = sign_b;
        end
        // Exact cancellation leaves the defaults in place: +0.
    end

endmodule

// File: rtl/fp_mantissa_adder.sv
// Registered sign-magnitude mantissa adder/subtractor with valid qualification.
// One cycle of latency, one operation accepted per cycle, no backpressure.
module fp_mantissa_adder
    import fp_mantissa_adder_pkg::*;
#(
    parameter int MANT_W = fp_mantissa_adder_pkg::MANT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              sign_a,
    input  logic              sign_b,
    input  logic [MANT_W-1:0] mantissa_a,
    input  logic [MANT_W-1:0] mantissa_b,
    output logic              out_valid,
    output logic [MANT_W:0]   sum_result,
    output logic              result_sign
);

    logic [MANT_W:0] sum_d;
    logic            sign_d;
    logic [MANT_W:0] sum_q;
    logic            sign_q;
    logic            valid_q;

    mantissa_addsub_core #(
        .W (MANT_W)
    ) u_core (
        .sign_a     (sign_a),
        .sign_b     (sign_b),
        .mantissa_a (mantissa_a),
        .mantissa_b (mantissa_b),
        .sum        (sum_d),
        .sign       (sign_d)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            sign_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            // Data only loads on valid, so X operands during idle never reach the outputs.
            if (in_valid) begin
                sum_q  <= sum_d;
                sign_q <= sign_d;
            end
        end
    end

    assign out_valid   = valid_q;
    assign sum_result  = sum_q;
    assign result_sign = sign_q;

endmodule

// File: tb/tb_fp_mantissa_adder.sv
// Directed self-checking bench for fp_mantissa_adder with hand-computed vectors.
module tb_fp_mantissa_adder;
    import fp_mantissa_adder_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      in_valid;
    logic      sign_a;
    logic      sign_b;
    mantissa_t mantissa_a;
    mantissa_t mantissa_b;
    logic      out_valid;
    sum_t      sum_result;
    logic      result_sign;

    int n_tests = 0;
    int n_fail  = 0;

    fp_mantissa_adder #(
        .MANT_W (MANT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .sign_a      (sign_a),
        .sign_b      (sign_b),
        .mantissa_a  (mantissa_a),
        .mantissa_b  (mantissa_b),
        .out_valid   (out_valid),
        .sum_result  (sum_result),
        .result_sign (result_sign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic go_idle();
        in_valid   = 1'b0;
        sign_a     = 1'bx;
        sign_b     = 1'bx;
        mantissa_a = 'x;
        mantissa_b = 'x;
    endtask

    // Called on a falling edge: drive one operation, check it after the next rising edge,
    // then return on the following falling edge with the inputs idle.
    task automatic op(input string tag, input logic sa, input logic sb,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_sum, input logic exp_sign);
        in_valid   = 1'b1;
        sign_a     = sa;
        sign_b     = sb;
        mantissa_a = a[MANT_W-1:0];
        mantissa_b = b[MANT_W-1:0];
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".sum"},   32'(sum_result), exp_sum);
        check({tag, ".sign"},  32'(result_sign), 32'(exp_sign));
        @(negedge clk);
        go_idle();
    endtask

    initial begin
        rst = 1'b1;
        go_idle();
        #1;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.sum",   32'(sum_result), 32'd0);
        check("rst.sign",  32'(result_sign), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        op("add_nocarry",  1'b0, 1'b0, 32'h400000, 32'h200000, 32'h0600000, 1'b0);
        op("add_carry",    1'b0, 1'b0, 32'hC00000, 32'hC00000, 32'h1800000, 1'b0);
        op("add_carry_neg",1'b1, 1'b1, 32'hC00000, 32'hC00000, 32'h1800000, 1'b1);
        op("add_max",      1'b1, 1'b1, 32'hFFFFFF, 32'hFFFFFF, 32'h1FFFFFE, 1'b1);
        op("sub_a_gt",     1'b0, 1'b1, 32'hC00000, 32'h400000, 32'h0800000, 1'b0);
        op("sub_b_gt",     1'b0, 1'b1, 32'h400000, 32'hC00000, 32'h0800000, 1'b1);
        op("sub_a_gt_neg", 1'b1, 1'b0, 32'h000005, 32'h000003, 32'h0000002, 1'b1);
        op("sub_b_gt_pos", 1'b1, 1'b0, 32'h000001, 32'hFFFFFF, 32'h0FFFFFE, 1'b0);
        op("zero_pos",     1'b0, 1'b0, 32'h000000, 32'h000000, 32'h0000000, 1'b0);
        op("zero_neg",     1'b1, 1'b1, 32'h000000, 32'h000000, 32'h0000000, 1'b1);
        op("cancel",       1'b1, 1'b0, 32'h9ABCDE, 32'h9ABCDE, 32'h0000000, 1'b0);

        // Idle cycle after the cancel: valid drops, data held at +0.
        @(posedge clk);
        #1;
        check("idle.valid", 32'(out_valid), 32'd0);
        check("idle.sum",   32'(sum_result), 32'd0);
        check("idle.sign",  32'(result_sign), 32'd0);
        @(negedge clk);

        // Back-to-back: op() returns on the next falling edge, so issues are consecutive.
        op("b2b0", 1'b0, 1'b0, 32'h123456, 32'h111111, 32'h0234567, 1'b0);
        op("b2b1", 1'b1, 1'b0, 32'h800000, 32'h000001, 32'h07FFFFF, 1'b1);
        op("b2b2", 1'b0, 1'b1, 32'h000010, 32'h000020, 32'h0000010, 1'b1);
        @(posedge clk);
        #1;
        check("b2b_idle.valid", 32'(out_valid), 32'd0);
        check("b2b_idle.sum",   32'(sum_result), 32'h0000010);
        check("b2b_idle.sign",  32'(result_sign), 32'd1);
        @(negedge clk);

        // Mid-stream asynchronous reset while out_valid is high.
        in_valid   = 1'b1;
        sign_a     = 1'b1;
        sign_b     = 1'b1;
        mantissa_a = 24'h300000;
        mantissa_b = 24'h100000;
        @(posedge clk);
        #1;
        check("pre_rst.valid", 32'(out_valid), 32'd1);
        check("pre_rst.sum",   32'(sum_result), 32'h0400000);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst.valid", 32'(out_valid), 32'd0);
        check("async_rst.sum",   32'(sum_result), 32'd0);
        check("async_rst.sign",  32'(result_sign), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold.valid", 32'(out_valid), 32'd0);
        check("rst_hold.sum",   32'(sum_result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        go_idle();

        op("post_rst", 1'b0, 1'b1, 32'h000100, 32'h0000FF, 32'h0000001, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_mantissa_adder.md
Name: fp_mantissa_adder

Overview:
- Sign-magnitude adder/subtractor for floating-point mantissas, including the hidden bit.
- Sits in the FP add datapath after exponent alignment and before normalisation/rounding.
- Produces a raw unnormalised magnitude one bit wider than the inputs, plus the result sign.
- Single registered stage with valid qualification.

Parameters:
- MANT_W, 24, mantissa width in bits including the hidden bit. The sum width is MANT_W+1.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands valid this cycle
- sign_a  input  1  sign of operand A (1 = negative)
- sign_b  input  1  sign of operand B
- mantissa_a  input  MANT_W  aligned magnitude of A
- mantissa_b  input  MANT_W  aligned magnitude of B
- out_valid  output  1  sum_result and result_sign are valid
- sum_result  output  MANT_W+1  raw magnitude; the MSB is the carry/overflow bit
- result_sign  output  1  sign of the result

Behaviour:
- Reset (asynchronous, rst=1): out_valid=0, sum_result=0, result_sign=0. Outputs are held while rst is high. Release is synchronous to the next clk edge.
- Latency: exactly 1 cycle. Operands sampled on edge N with in_valid=1 appear on the outputs after edge N, with out_valid=1.
- No backpressure. A new operation may be accepted every cycle.
- in_valid=0 on an edge: out_valid=0, and sum_result/result_sign hold their previous values.
- Same signs (sign_a == sign_b):
  - sum_result = zero-extended mantissa_a + mantissa_b; the carry lands in bit MANT_W.
  - result_sign = sign_a, so -0 + -0 yields sign 1.
- Different signs, mantissa_a > mantissa_b: sum_result = a - b, result_sign = sign_a.
- Different signs, mantissa_b > mantissa_a: sum_result = b - a, result_sign = sign_b.
- Different signs, equal magnitudes: sum_result = 0, result_sign = 0 (+0).
- sum_result is never negative or two's-complement. Bit MANT_W can only be 1 in the same-sign case.
- Pure unsigned arithmetic. There is no normalisation, rounding, or exponent handling in this block.
- Inputs may be X while in_valid=0. Outputs must stay X-free after reset.

Decomposition:
- Shared FP package holds:
  - the MANT_W constant (default 24);
  - a typedef for the mantissa (MANT_W bits);
  - a typedef for the raw sum (MANT_W+1 bits).
- One combinational sub-module, mantissa_addsub_core, performs:
  - the magnitude compare;
  - add/subtract selection;
  - sign determination.
- The top level adds the input handshake and the output register stage with asynchronous reset.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, sum_result=0, result_sign=0 immediately, with no clock edge needed.
- Same-sign add, no carry: sign_a=0, sign_b=0, a=0x400000, b=0x200000, in_valid=1 -> next cycle sum_result=0x0600000, result_sign=0, out_valid=1.
- Same-sign add with carry: sign_a=0, sign_b=0, a=b=0xC00000 -> sum_result=0x1800000, result_sign=0. Repeat with both signs 1 -> same sum, result_sign=1.
- Subtract, A larger: sign_a=0, sign_b=1, a=0xC00000, b=0x400000 -> sum_result=0x0800000, result_sign=0.
- Subtract, B larger: sign_a=0, sign_b=1, a=0x400000, b=0xC00000 -> sum_result=0x0800000, result_sign=1.
- Zeros and cancellation:
  - a=b=0, both signs 0 -> sum 0, sign 0.
  - sign_a=1, sign_b=0, a=b=0x9ABCDE -> sum 0, sign 0.
- Throughput: back-to-back in_valid over 3 cycles, then one idle cycle -> out_valid pattern 1,1,1,0. Results match the rules above in order, and are held during the idle cycle.
